// File: rtl/four_button_debounce.sv
// Four independent channels: 2-flop synchroniser, then a STABLE/PENDING
// stability filter that emits a clean active-low level plus press/release pulses.
module four_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_btn_raw,
    output logic [3:0] o_btn_n,
    output logic [3:0] o_press,
    output logic [3:0] o_release
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0] s1_q;
    logic [3:0] s2_q;

    // Synchroniser idles high so released buttons never look pressed after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= 4'b1111;
            s2_q <= 4'b1111;
        end else begin
            s1_q <= i_btn_raw;
            s2_q <= s1_q;
        end
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             btn_q, btn_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             accept;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            btn_d   = btn_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            accept  = 1'b0;
            case (state_q)
                STABLE: begin
                    cnt_d = '0;
                    if (s2_q[gi] != btn_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = PENDING;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PENDING: begin
                    if (s2_q[gi] == btn_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
            if (accept) begin
                state_d = STABLE;
                cnt_d   = '0;
                btn_d   = s2_q[gi];
                press_d = ~s2_q[gi];
                rel_d   = s2_q[gi];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= STABLE;
                cnt_q   <= '0;
                btn_q   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                btn_q   <= btn_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign o_btn_n[gi]   = btn_q;
        assign o_press[gi]   = press_q;
        assign o_release[gi] = rel_q;
    end

endmodule

// File: doc/four_button_debounce.md
# four_button_debounce

Four-channel input conditioner that sits directly upstream of the `four_button_ctrl` button-flag stage. It takes the raw active-low K1/K4/K7/K10 pad signals, which are asynchronous and bouncing, and synchronises each one to the system clock. It then filters each channel with a per-channel stability counter. Its outputs are a clean active-low level that drives `four_button_ctrl.i_btn` directly, plus one-cycle press and release pulses for the LED-control logic.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive cycles a synchronised input must differ from the accepted level before it is accepted (1 ms at 50 MHz). Legal range is 1 to 2^CNT_W − 1.
- `CNT_W`, default 16: width of each channel's stability counter.
- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_btn_raw`  in  4  raw button pads, active-low (0 = pressed), asynchronous to `i_clk`.
- `o_btn_n`  out  4  debounced level, active-low, registered.
- `o_press`  out  4  one-cycle pulse when a channel's `o_btn_n` goes 1→0.
- `o_release`  out  4  one-cycle pulse when a channel's `o_btn_n` goes 0→1.

## Operation
- The four channels are identical and fully independent. Channel n uses bit n of every port.
- **Synchroniser:** two flops per channel, `s1 <= i_btn_raw[n]` and `s2 <= s1`. Only `s2` is used downstream.
- **FSM per channel**, with states STABLE and PENDING and a counter `cnt[CNT_W-1:0]`:
  - STABLE, `s2 == o_btn_n[n]`: stay in STABLE; `cnt <= 0`.
  - STABLE, `s2 != o_btn_n[n]`: go to PENDING; `cnt <= 1`.
    - Exception when DEBOUNCE_CYCLES = 1: accept immediately, as in the accept case below.
  - PENDING, `s2 == o_btn_n[n]` (bounce back): go to STABLE; `cnt <= 0`; no output change.
  - PENDING, `s2 != o_btn_n[n]`, `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - PENDING, `s2 != o_btn_n[n]`, `cnt == DEBOUNCE_CYCLES-1` (accept):
    - `o_btn_n[n] <= s2`;
    - pulse `o_press[n]` if `s2 == 0`, otherwise pulse `o_release[n]`;
    - go to STABLE; `cnt <= 0`.
- **Pulses** are registered. Each is high for exactly one cycle, in the same cycle the new `o_btn_n[n]` value first appears. `o_press[n]` and `o_release[n]` are never high together.
- **Counter** never wraps: it is bounded by DEBOUNCE_CYCLES-1 ≤ 2^CNT_W − 2.
- **Simultaneous events:** several channels may accept in the same cycle. Every channel that accepts asserts its own pulse bit in that cycle.

## Timing
- **Reset values:** `s1 = s2 = 1`, `o_btn_n = 4'b1111`, `o_press = o_release = 4'b0000`, all counters 0, all FSMs in STABLE.
- **Latency:** count edges from the first rising edge after a clean raw transition, as edge 1.
  - `s2` changes at edge 2.
  - `o_btn_n` and the pulse update at edge DEBOUNCE_CYCLES + 2.
- **Glitch rejection:** a raw pulse that keeps `s2` changed for fewer than DEBOUNCE_CYCLES consecutive cycles produces no output change and no pulse.
- **Reset mid-operation:** asserting reset immediately forces all reset values; any pending count is discarded.
  - If a button is held low across reset release, `o_press` fires at edge DEBOUNCE_CYCLES + 2 after reset deassertion.
- **Output timing:** no combinational path from any input to any output.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES = 4 and CNT_W = 3.
- **Reset:** hold `i_rst_n = 0` with `i_btn_raw = 4'b0000`, then release it.
  - During reset: `o_btn_n = 4'b1111` and both pulse vectors are 0.
  - At edge 6 after release: `o_btn_n = 4'b0000` and `o_press = 4'b1111` for one cycle.
- **Clean press/release, channel 0:** drive bit 0 low cleanly.
  - `o_btn_n[0]` goes 0 and `o_press[0]` pulses at edge 6.
  - Drive bit 0 high for 20 cycles: `o_release[0]` pulses at edge 6 and `o_btn_n[0]` returns to 1.
- **Bounce, channel 1:** raw pattern 0,1,0,0,1,0 (one value per cycle), then steady 0.
  - No pulse appears during the bounce.
  - Exactly one `o_press[1]` occurs, at edge 6 after the last 1→0 raw transition.
- **Glitch rejection:** a 3-cycle low pulse on channel 2.
  - `o_btn_n` stays 4'b1111; `o_press` and `o_release` stay 0.
- **Simultaneous and independent channels:** channels 2 and 3 go low in the same cycle while channel 0 is already held low.
  - `o_press = 4'b1100` for a single cycle; `o_btn_n` goes 4'b1110 → 4'b0010.
- **Reset mid-count:** channel 3 goes low; assert reset at edge 4.
  - No pulse appears.
  - After release with the raw input still low, `o_press[3]` fires at edge 6.
